// File: rtl/reflet_boot_pkg.sv
// Shared state type and default image header for the ROM boot loader.
package reflet_boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        COPY,
        DONE,
        ERROR
    } boot_state_t;

    localparam logic [31:0] DEFAULT_MAGIC = 32'h4153524D;

    // Header byte idx of the magic word; byte 0 lives in bits 31:24.
    function automatic logic [7:0] magic_byte(input logic [31:0] magic, input logic [1:0] idx);
        return magic[31 - 8*idx -: 8];
    endfunction

endpackage

// File: rtl/rom_boot_loader_if.sv
// ROM read port and RAM write port of the boot loader, bundled as one bus.
interface rom_boot_loader_if #(
    parameter int ROM_AW = 7,
    parameter int RAM_AW = 8
);

    logic              rom_enable_out;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram_data;
    logic              ram_we;
    logic              ram_wait;

    modport master (
        output rom_enable_out, rom_addr, ram_addr, ram_data, ram_we,
        input  rom_data, ram_wait
    );

    modport slave (
        input  rom_enable_out, rom_addr, ram_addr, ram_data, ram_we,
        output rom_data, ram_wait
    );

endinterface

// File: rtl/rom_boot_loader.sv
// Checks the ROM image header, copies the ROM payload into RAM and then
// releases the CPU reset; a header mismatch parks the block in ERROR.
module rom_boot_loader
    import reflet_boot_pkg::*;
#(
    parameter int          ROM_AW   = 7,
    parameter int          RAM_AW   = 8,
    parameter int          RAM_BASE = 0,
    parameter logic [31:0] MAGIC    = DEFAULT_MAGIC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    rom_boot_loader_if.master bus,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    localparam logic [ROM_AW-1:0] ROM_LAST  = {ROM_AW{1'b1}};
    localparam logic [RAM_AW-1:0] RAM_START = RAM_AW'(RAM_BASE);

    boot_state_t       state, state_d;
    logic              rom_en_q, rom_en_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_data_q, ram_data_d;
    logic [1:0]        hdr_idx_q, hdr_idx_d;
    logic              rd_valid_q, rd_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic [7:0]        skid_data_q, skid_data_d;
    logic              issue;
    logic              stall;

    assign bus.rom_enable_out = rom_en_q;
    assign bus.rom_addr       = rom_addr_q;
    assign bus.ram_we         = ram_we_q;
    assign bus.ram_addr       = ram_addr_q;
    assign bus.ram_data       = ram_data_q;

    assign stall = ram_we_q && bus.ram_wait;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            rom_en_q     <= 1'b0;
            rom_addr_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= RAM_START;
            ram_data_q   <= 8'h00;
            hdr_idx_q    <= 2'd0;
            rd_valid_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= 8'h00;
            cpu_reset    <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state        <= state_d;
            rom_en_q     <= rom_en_d;
            rom_addr_q   <= rom_addr_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_data_q   <= ram_data_d;
            hdr_idx_q    <= hdr_idx_d;
            rd_valid_q   <= rd_valid_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            cpu_reset    <= (state_d == DONE);
            done         <= (state_d == DONE);
            error        <= (state_d == ERROR);
        end
    end

    // rd_valid marks rom_data as a fresh byte for an address that was issued
    // (advanced past) last cycle; the skid keeps that byte when a stall hits,
    // because the held ROM address overwrites rom_data on the next edge.
    always_comb begin
        state_d      = state;
        rom_en_d     = rom_en_q;
        rom_addr_d   = rom_addr_q;
        ram_we_d     = ram_we_q;
        ram_addr_d   = ram_addr_q;
        ram_data_d   = ram_data_q;
        hdr_idx_d    = hdr_idx_q;
        rd_valid_d   = 1'b0;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        issue        = 1'b0;

        case (state)
            IDLE: begin
                rom_en_d   = 1'b0;
                ram_we_d   = 1'b0;
                rom_addr_d = '0;
                hdr_idx_d  = 2'd0;
                if (start) begin
                    state_d  = CHECK;
                    rom_en_d = 1'b1;
                end
            end

            CHECK: begin
                issue = 1'b1;
                if (rd_valid_q) begin
                    if (bus.rom_data != magic_byte(MAGIC, hdr_idx_q)) begin
                        state_d  = ERROR;
                        issue    = 1'b0;
                        rom_en_d = 1'b0;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 2'd1;
                        if (hdr_idx_q == 2'd3) begin
                            state_d = COPY;
                        end
                    end
                end
            end

            COPY: begin
                if (stall) begin
                    if (rd_valid_q && !skid_valid_q) begin
                        skid_valid_d = 1'b1;
                        skid_data_d  = bus.rom_data;
                    end
                end else begin
                    issue = rom_en_q;
                    if (ram_we_q) begin
                        ram_addr_d = ram_addr_q + RAM_AW'(1);
                    end
                    ram_we_d = skid_valid_q || rd_valid_q;
                    if (skid_valid_q) begin
                        ram_data_d = skid_data_q;
                    end else if (rd_valid_q) begin
                        ram_data_d = bus.rom_data;
                    end
                    skid_valid_d = 1'b0;
                    if (!rom_en_q && !rd_valid_q && !skid_valid_q) begin
                        state_d = DONE;
                    end
                end
            end

            DONE, ERROR: begin
                rom_en_d = 1'b0;
                ram_we_d = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // The address counter stops at the last ROM byte instead of wrapping.
        if (issue) begin
            rd_valid_d = 1'b1;
            if (rom_addr_q == ROM_LAST) begin
                rom_en_d = 1'b0;
            end else begin
                rom_addr_d = rom_addr_q + ROM_AW'(1);
            end
        end
    end

endmodule

// File: doc/rom_boot_loader.md
ROM_BOOT_LOADER -- requirements
Module: rom_boot_loader

Interface
REQ-001 Parameter ROM_AW, default 7: ROM address width; ROM depth is 2^ROM_AW bytes.
REQ-002 Parameter RAM_AW, default 8: RAM address width.
REQ-003 Parameter RAM_BASE, default 0: first RAM address written.
REQ-004 Parameter MAGIC, default 32'h4153524D: the ASCII "ASRM" image header, first byte in bits 31:24.
REQ-005 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-low reset.
REQ-007 Port start, input, 1: begin a boot; sampled only in IDLE.
REQ-008 Port rom_enable_out, output, 1: drives the ROM output enable.
REQ-009 Port rom_addr, output, ROM_AW: ROM byte address.
REQ-010 Port rom_data, input, 8: ROM read data; valid one clk after rom_addr/rom_enable_out were presented.
REQ-011 Port ram_addr, output, RAM_AW: RAM write address.
REQ-012 Port ram_data, output, 8: RAM write data.
REQ-013 Port ram_we, output, 1: RAM write strobe; one byte is written per cycle with ram_we=1 and ram_wait=0.
REQ-014 Port ram_wait, input, 1: RAM stall; a write is accepted only when ram_wait=0.
REQ-015 Port cpu_reset, output, 1: active-low CPU reset; held low until the boot succeeds.
REQ-016 Port done, output, 1: image copied successfully.
REQ-017 Port error, output, 1: header mismatch.

Function
REQ-018 The FSM shall have exactly the states IDLE, CHECK, COPY, DONE and ERROR.
REQ-019 IDLE behaviour: rom_enable_out=0, ram_we=0; start=1 moves the FSM to CHECK on the next edge with rom_addr=0.
REQ-020 CHECK: issue ROM addresses 0..3, one per cycle, with rom_enable_out=1; compare each returned byte, one cycle later, against the corresponding MAGIC byte.
REQ-021 Any CHECK mismatch: move to ERROR on the next edge; no RAM write occurs.
REQ-022 All 4 header bytes match: move to COPY with no idle cycle; address 4 is issued in the same cycle byte 3 is compared.
REQ-023 COPY write mapping: ROM byte at address a (4 <= a <= 2^ROM_AW-1) is written to ram_addr = RAM_BASE + (a-4), truncated to RAM_AW bits.
REQ-024 COPY throughput: one byte per cycle while ram_wait=0.
REQ-025 ram_wait=1 while ram_we=1: hold ram_we, ram_addr, ram_data and rom_addr stable; do not advance the ROM address counter.
REQ-026 ROM address counter: never wraps; after the last address (127 at default) is issued, no further reads occur.
REQ-027 COPY exit: move to DONE on the edge at which the final byte's write is accepted.
REQ-028 DONE: done=1 and cpu_reset=1, held until reset.
REQ-029 ERROR: error=1 and cpu_reset=0, held until reset.
REQ-030 start outside IDLE shall be ignored; done and error shall never both be 1.
REQ-031 With ram_wait=0 throughout, done shall rise exactly 4 + (2^ROM_AW-4) + 2 cycles after the start-sampling edge (130 at default).

Reset
REQ-032 While reset=0 at a rising edge: state=IDLE, rom_enable_out=0, rom_addr=0, ram_we=0, ram_addr=RAM_BASE, ram_data=0, cpu_reset=0, done=0, error=0.
REQ-033 Reset mid-CHECK or mid-COPY shall abort immediately; RAM contents already written are not restored; a new start is required afterwards.

Structure
REQ-034 Package reflet_boot_pkg shall hold the state enumeration and the default MAGIC constant.
REQ-035 The block shall be a single module (FSM, ROM address counter, RAM write register) with no sub-module; the ROM is instantiated outside it.

Verification
REQ-036 Scenario: default ROM image, start pulse, ram_wait=0 -> 124 writes to RAM 0x00..0x7B (RAM[0]=0x14, RAM[1]=0x3C, RAM[0x6C]=0x02); done rises 130 cycles after start; cpu_reset rises with it.
REQ-037 Scenario: ROM byte 2 = 0x00 -> error=1 within 4 cycles of the mismatch compare; ram_we never asserted; cpu_reset stays 0.
REQ-038 Scenario: ram_wait=1 for 3 cycles during the write to RAM 0x10 -> that write is held stable for 3 cycles; final RAM image identical to REQ-036; done delayed by exactly 3 cycles.
REQ-039 Scenario: reset=0 asserted at byte 50 of COPY, then a new start -> all outputs at reset values the next cycle; the second boot completes as in REQ-036.
REQ-040 Scenario: start held high through the whole boot, and start pulsed in DONE -> exactly one boot is performed; done stays 1.
REQ-041 Scenario: RAM_BASE=0xF0, RAM_AW=8 -> ram_addr wraps 0xFF->0x00 after 16 writes; the last write goes to 0x6B.
